// File: rtl/divider_pkg.sv
// Shared FSM state type and derived constants for the sequential signed divider.
// Widths and saturation limits are functions of the divider's parameters.
// Sized for results narrower than 64 bits.
package divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

    function automatic int n_iter(input int dw, input int fw);
        return dw + fw;
    endfunction

    function automatic int res_w(input int iw, input int fw);
        return 1 + iw + fw;
    endfunction

    // Wide enough to hold the raw quotient magnitude and both saturation limits.
    function automatic int cmp_w(input int n, input int rw);
        return ((n > rw) ? n : rw) + 1;
    endfunction

    function automatic longint unsigned sat_pos_mag(input int rw);
        return (64'd1 << (rw - 1)) - 64'd1;
    endfunction

    function automatic longint unsigned sat_neg_mag(input int rw);
        return 64'd1 << (rw - 1);
    endfunction

endpackage

// File: rtl/seq_signed_divider.sv
// Signed fixed-point divider: one restoring shift-subtract step per cycle, saturating result.
// Latency: accept at edge k, out_valid after edge k+DW+FW+1, independent of operands.
// Backpressure: single operation in flight; result held in DONE until out_ready.
module seq_signed_divider
    import divider_pkg::*;
#(
    parameter int DW = 16,
    parameter int FW = 10,
    parameter int IW = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic                 in_ready,
    output logic [IW+FW:0]       y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf,
    output logic                 dbz
);

    localparam int N    = n_iter(DW, FW);
    localparam int RW   = res_w(IW, FW);
    localparam int CW   = cmp_w(N, RW);
    localparam int CNTW = $clog2(N + 1);

    localparam logic [CW-1:0]   POS_LIM  = CW'(sat_pos_mag(RW));
    localparam logic [CW-1:0]   NEG_LIM  = CW'(sat_neg_mag(RW));
    localparam logic [RW-1:0]   Y_MAX    = POS_LIM[RW-1:0];
    localparam logic [RW-1:0]   Y_MIN    = NEG_LIM[RW-1:0];
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N);

    div_state_t      state, state_n;
    logic            accept, step, finish;
    logic [CNTW-1:0] cnt;
    logic            sign, a_zero;
    logic [DW-1:0]   amag_in, bmag_in, bmag, rem;
    logic [N-1:0]    nq;
    logic [DW:0]     trial;
    logic [DW-1:0]   diff;
    logic            ge;
    logic [CW-1:0]   mag;
    logic [RW-1:0]   y_fin;
    logic            ovf_fin;

    assign amag_in = a[DW-1] ? $unsigned(-a) : $unsigned(a);
    assign bmag_in = b[DW-1] ? $unsigned(-b) : $unsigned(b);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // nq shifts the numerator out of its MSB while quotient bits enter at its LSB.
    assign trial = {rem, nq[N-1]};
    assign ge    = (trial >= {1'b0, bmag});
    assign diff  = trial[DW-1:0] - bmag;

    always_comb begin
        mag     = CW'(nq);
        y_fin   = '0;
        ovf_fin = 1'b0;
        if (bmag == '0) begin
            y_fin = a_zero ? '0 : (sign ? Y_MIN : Y_MAX);
        end else if (!sign) begin
            if (mag > POS_LIM) begin
                y_fin   = Y_MAX;
                ovf_fin = 1'b1;
            end else begin
                y_fin = mag[RW-1:0];
            end
        end else if (mag > NEG_LIM) begin
            y_fin   = Y_MIN;
            ovf_fin = 1'b1;
        end else begin
            y_fin = ~mag[RW-1:0] + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sign   <= 1'b0;
            a_zero <= 1'b0;
            bmag   <= '0;
            rem    <= '0;
            nq     <= '0;
            y      <= '0;
            ovf    <= 1'b0;
            dbz    <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            sign   <= a[DW-1] ^ b[DW-1];
            a_zero <= (amag_in == '0);
            bmag   <= bmag_in;
            rem    <= '0;
            nq     <= {amag_in, {FW{1'b0}}};
        end else if (step) begin
            rem <= ge ? diff : trial[DW-1:0];
            nq  <= {nq[N-2:0], ge};
            cnt <= cnt + CNTW'(1);
        end else if (finish) begin
            y   <= y_fin;
            ovf <= ovf_fin;
            dbz <= (bmag == '0);
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: directed boundary table, hold/ignore/abort cases, random vs. arithmetic model.
module tb_seq_signed_divider;

    localparam int DW = 16;
    localparam int FW = 10;
    localparam int IW = 9;
    localparam int RW = 1 + IW + FW;

    logic                 clk = 1'b0;
    logic                 rst, start, out_ready;
    logic signed [DW-1:0] a, b;
    logic                 in_ready, out_valid, ovf, dbz;
    logic [RW-1:0]        y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_signed_divider #(.DW(DW), .FW(FW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .in_ready(in_ready), .y(y), .out_valid(out_valid),
        .out_ready(out_ready), .ovf(ovf), .dbz(dbz)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact rational quotient, truncated toward zero, then clamped.
    task automatic ref_div(input longint ra, input longint rb,
                           output logic [RW-1:0] ey, output logic eovf, output logic edbz);
        longint ma, mb, q, lim;
        lim  = longint'(1) << (RW - 1);
        ma   = (ra < 0) ? -ra : ra;
        mb   = (rb < 0) ? -rb : rb;
        eovf = 1'b0;
        edbz = 1'b0;
        if (rb == 0) begin
            edbz = 1'b1;
            ey   = (ra == 0) ? RW'(0) : ((ra > 0) ? RW'(lim - 1) : RW'(-lim));
        end else begin
            q = (ma * (longint'(1) << FW)) / mb;
            if ((ra < 0) != (rb < 0)) begin
                if (q > lim) begin ey = RW'(-lim); eovf = 1'b1; end
                else ey = RW'(-q);
            end else begin
                if (q > lim - 1) begin ey = RW'(lim - 1); eovf = 1'b1; end
                else ey = RW'(q);
            end
        end
    endtask

    // Called right after a posedge (+#1). hold: cycles to stall out_ready; poke: pulse start mid-CALC.
    task automatic run_op(input string tag, input longint ta, input longint tb_v,
                          input logic [RW-1:0] ey, input logic eovf, input logic edbz,
                          input int hold, input bit poke);
        int lat;
        out_ready = (hold == 0);
        chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        a = DW'(ta);
        b = DW'(tb_v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (poke && lat == 5) begin
                a = 16'sd123;
                b = -16'sd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, "/latency"}, 64'(lat), 64'd27);
        chk({tag, "/y"}, 64'(y), 64'(ey));
        chk({tag, "/ovf"}, 64'(ovf), 64'(eovf));
        chk({tag, "/dbz"}, 64'(dbz), 64'(edbz));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_vld"}, 64'(out_valid), 64'd1);
            chk({tag, "/hold_y"}, 64'(y), 64'(ey));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "/vld_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin : main
        int da[12]  = '{7, -1, 1000, -32768, 5, -5, 0, -7, 511, -512, 512, -32768};
        int db[12]  = '{2, 3, 1, 1, 0, 0, 0, 2, 1, 1, 1, -32768};
        logic [RW-1:0] dy[12] = '{20'h00E00, 20'hFFEAB, 20'h7FFFF, 20'h80000, 20'h7FFFF,
                                  20'h80000, 20'h00000, 20'hFF200, 20'h7FC00, 20'h80000,
                                  20'h7FFFF, 20'h00400};
        bit dovf[12] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
        bit ddbz[12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        logic [RW-1:0] ey;
        logic eovf, edbz;
        logic [15:0] r;
        longint ra, rb;
        bit seen_vld;

        rst = 1'b1; start = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst/in_ready", 64'(in_ready), 64'd1);
        chk("rst/out_valid", 64'(out_valid), 64'd0);
        chk("rst/y", 64'(y), 64'd0);
        chk("rst/ovf", 64'(ovf), 64'd0);
        chk("rst/dbz", 64'(dbz), 64'd0);

        for (int i = 0; i < 12; i++)
            run_op($sformatf("dir%0d", i), longint'(da[i]), longint'(db[i]),
                   dy[i], dovf[i], ddbz[i], 0, 1'b0);

        run_op("hold_poke", 7, 2, 20'h00E00, 1'b0, 1'b0, 5, 1'b1);

        // Abort mid-CALC, then confirm no result ever appears for it.
        a = 16'sd7; b = 16'sd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort/in_ready", 64'(in_ready), 64'd1);
        chk("abort/out_valid", 64'(out_valid), 64'd0);
        chk("abort/y", 64'(y), 64'd0);
        seen_vld = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen_vld = 1'b1;
        end
        chk("abort/no_result", 64'(seen_vld), 64'd0);
        run_op("after_abort", 7, 2, 20'h00E00, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            r  = 16'($urandom);
            ra = longint'($signed(r));
            case ($urandom_range(0, 3))
                0:       rb = longint'($urandom_range(0, 16)) - 8;
                1:       rb = longint'($urandom_range(0, 600)) - 300;
                default: begin r = 16'($urandom); rb = longint'($signed(r)); end
            endcase
            ref_div(ra, rb, ey, eovf, edbz);
            run_op($sformatf("rnd%0d", i), ra, rb, ey, eovf, edbz, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
